rgb_pwm_driver: RTL and testbench
=================================

// Module: rgb_pwm_driver
// PURPOSE
//   Three-channel PWM generator that drives the board RGB LED pins from 8-bit duty values.
//   Sits directly upstream of the RGB pads in the rgb2 top, fed by a colour sequencer.
//   Duty values load through a valid/ready handshake into a shadow register.
//   Updates take effect only at a PWM period boundary, so a period never carries a mixed colour.
// PARAMETERS
//   WIDTH      8   duty/counter width; period = 2**WIDTH ticks
//   PRESCALE   47  clk cycles per PWM tick (>=1); 12 MHz/47/256 ~= 1 kHz PWM
//   ACTIVE_LOW 1   1: RGB_* low = LED on (iceBlinkPico pads); 0: high = on
// PORTS
//   clk        in   1      system clock (12 MHz)
//   reset      in   1      synchronous, active-high reset
//   enable     in   1      1: run PWM; 0: hold counter at 0, all channels off
//   in_valid   in   1      duty triple valid
//   in_ready   out  1      driver can accept a triple (shadow register empty)
//   in_r       in   WIDTH  red duty
//   in_g       in   WIDTH  green duty
//   in_b       in   WIDTH  blue duty
//   RGB_R      out  1      red pad drive (polarity per ACTIVE_LOW)
//   RGB_G      out  1      green pad drive
//   RGB_B      out  1      blue pad drive
//   period_start out 1     1-cycle pulse when counter wraps to 0 (enable=1 only)
// BEHAVIOUR
//   Reset (sync, highest priority, may occur mid-period):
//     presc=0, cnt=0, active duties=0, shadow empty, in_ready=1, period_start=0.
//     All RGB_* at "off" level (1 if ACTIVE_LOW else 0).
//   Prescaler: presc counts 0..PRESCALE-1 while enable=1; tick=1 when presc==PRESCALE-1.
//     presc wraps to 0 on tick. PRESCALE=1 -> tick every cycle.
//   Counter: on tick, cnt increments mod 2**WIDTH.
//     The tick with cnt==2**WIDTH-1 is the wrap event: cnt->0, period_start=1 next cycle.
//   Handshake: accept = in_valid & in_ready; on accept in_r/g/b latch into shadow, shadow full.
//     in_ready = ~shadow_full (registered state, not combinational on in_valid).
//   Shadow transfer: on the wrap event with shadow full, active duties<=shadow, shadow empties.
//     in_ready returns 1 the next cycle.
//     Accept and wrap in the same cycle cannot collide (in_ready=0 when shadow full).
//     If shadow was empty at the wrap, that wrap leaves active unchanged.
//   Output: per channel on = enable & (cnt < duty_active); RGB_x registered, 1-cycle lag behind cnt.
//     Pad = on ^ ACTIVE_LOW.
//     duty 0 -> never on; duty 2**WIDTH-1 -> on for 255 of 256 ticks (full-on not provided).
//   enable=0: presc and cnt forced to 0, outputs off next cycle, no period_start.
//     Handshake still accepts one triple into shadow; the transfer happens at the first wrap after enable=1.
//     Exception: a shadow loaded while active duties are reset values (first load after reset) transfers immediately.
//     That transfer happens on the cycle after accept, so the first colour shows without a dead period.
//   Reset mid-operation discards the shadow and active duties; no partial period is completed.
// TESTING (WIDTH=8, PRESCALE=1, ACTIVE_LOW=1 unless noted)
//   1 reset 3 cycles, enable=1, no load -> RGB_R/G/B stay 1; period_start every 256 cycles; in_ready=1
//   2 after reset load (64,128,255), enable=1 -> per 256-cycle period: R low 64, G low 128, B low 255 cycles; no dead period
//   3 mid-period load (10,10,10) over active (200,0,0) -> in_ready=0 until wrap; the old period completes with R low 200;
//     the next period has all three low 10 cycles; in_ready=1 the cycle after the wrap
//   4 in_valid held high with a new triple every cycle -> exactly one accept per period;
//     accepted values are the ones present when in_ready=1
//   5 enable dropped at cnt=100 then raised 50 cycles later -> outputs 1 within 1 cycle;
//     cnt restarts at 0; period_start first seen 256 cycles after re-enable
//   6 PRESCALE=4, ACTIVE_LOW=0, duty R=3, reset asserted at cnt=2 -> RGB_R high for 12 clk per 1024-clk period;
//     after reset RGB_R=0 and in_ready=1

Source files
------------

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver
//   Three-channel PWM generator for the board RGB LED pads. A colour
//   sequencer hands over 8-bit duty triples through a valid/ready handshake
//   into a one-deep shadow register. The shadow is copied into the active
//   duties only when the PWM counter wraps, so every period shows a single
//   colour. The very first triple after reset is copied straight away, so
//   the first colour appears without waiting for a dead period.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   enable        1: run PWM; 0: counter held at 0, all channels off
//   in_valid      duty triple valid
//   in_ready      shadow register empty, triple can be accepted
//   in_r/g/b      red/green/blue duty (WIDTH bits)
//   RGB_R/G/B     pad drives, polarity set by ACTIVE_LOW
//   period_start  one-cycle pulse after the counter wraps to 0
module rgb_pwm_driver #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE   = 47,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0] in_g,
  input  logic [WIDTH-1:0] in_b,
  output logic             RGB_R,
  output logic             RGB_G,
  output logic             RGB_B,
  output logic             period_start
);

  localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST  = '1;

  // Map a logical "LED on" to the pad level.
  function automatic logic pad_level(input logic on);
    return on ^ ACTIVE_LOW;
  endfunction

  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty_r, duty_g, duty_b;
  logic [WIDTH-1:0] shadow_r, shadow_g, shadow_b;
  logic             shadow_full;
  // Set while the active duties still hold their reset values; lets the
  // first triple go live without waiting for a wrap.
  logic             fresh;

  logic tick;
  logic wrap;
  logic accept;
  logic transfer;

  assign tick     = enable & (presc == PRESC_LAST);
  assign wrap     = tick & (cnt == CNT_LAST);
  assign accept   = in_valid & ~shadow_full;
  assign transfer = shadow_full & (wrap | fresh);
  assign in_ready = ~shadow_full;

  // Prescaler and period counter
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      presc <= '0;
      cnt   <= '0;
    end else if (tick) begin
      presc <= '0;
      cnt   <= cnt + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Handshake state and active duties
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_full <= 1'b0;
      fresh       <= 1'b1;
      duty_r      <= '0;
      duty_g      <= '0;
      duty_b      <= '0;
    end else if (transfer) begin
      shadow_full <= 1'b0;
      fresh       <= 1'b0;
      duty_r      <= shadow_r;
      duty_g      <= shadow_g;
      duty_b      <= shadow_b;
    end else if (accept) begin
      shadow_full <= 1'b1;
    end
  end

  // Shadow data is only meaningful while shadow_full is set, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      shadow_r <= in_r;
      shadow_g <= in_g;
      shadow_b <= in_b;
    end
  end

  // Output stage: pads lag the counter by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      RGB_R        <= pad_level(1'b0);
      RGB_G        <= pad_level(1'b0);
      RGB_B        <= pad_level(1'b0);
      period_start <= 1'b0;
    end else begin
      RGB_R        <= pad_level(enable & (cnt < duty_r));
      RGB_G        <= pad_level(enable & (cnt < duty_g));
      RGB_B        <= pad_level(enable & (cnt < duty_b));
      period_start <= wrap;
    end
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver
//   Drives two instances of rgb_pwm_driver from the same inputs:
//   instance 0 with PRESCALE=1, ACTIVE_LOW=1 and instance 1 with
//   PRESCALE=4, ACTIVE_LOW=0. A reference model tracks elapsed enabled
//   clocks, duties and the shadow slot; expected outputs are queued per
//   cycle and a monitor compares them against both instances.
module tb_rgb_pwm_driver;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       in_valid;
  logic [7:0] in_r, in_g, in_b;

  logic rdy0, r0, g0, b0, ps0;
  logic rdy1, r1, g1, b1, ps1;

  rgb_pwm_driver #(.WIDTH(8), .PRESCALE(1), .ACTIVE_LOW(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .in_ready(rdy0), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .RGB_R(r0), .RGB_G(g0), .RGB_B(b0), .period_start(ps0)
  );

  rgb_pwm_driver #(.WIDTH(8), .PRESCALE(4), .ACTIVE_LOW(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .in_ready(rdy1), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .RGB_R(r1), .RGB_G(g1), .RGB_B(b1), .period_start(ps1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [1:0] rdy;
    logic [1:0] ps;
    logic [2:0] rgb0;
    logic [2:0] rgb1;
  } exp_t;

  exp_t q[$];

  int total = 0;
  int fails = 0;

  // Reference model state, one slot per instance
  int e  [2];     // enabled clocks since reset / last disable
  int dr [2][3];  // active duties
  int sh [2][3];  // shadow duties
  bit sf [2];     // shadow full
  bit fr [2];     // active duties still at reset values

  function automatic int presc_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic bit al_of(input int k);
    return (k == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic model_step(input bit rst, input bit en, input bit vld,
                            input int r, input int g, input int b,
                            output exp_t x);
    int          cnt;
    bit          wrap;
    bit          acc;
    logic [2:0]  rg;
    int          in_d[3];
    in_d[0] = r; in_d[1] = g; in_d[2] = b;
    x = '0;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        e[k]  = 0;
        sf[k] = 1'b0;
        fr[k] = 1'b1;
        for (int c = 0; c < 3; c++) dr[k][c] = 0;
        rg = {3{al_of(k)}};
        x.ps[k]  = 1'b0;
        x.rdy[k] = 1'b1;
      end else begin
        cnt  = (e[k] / presc_of(k)) % 256;
        wrap = en && (((e[k] + 1) % (presc_of(k) * 256)) == 0);
        for (int c = 0; c < 3; c++)
          rg[2-c] = (en && (cnt < dr[k][c])) ^ al_of(k);
        x.ps[k] = wrap;
        acc = vld && !sf[k];
        if (sf[k] && (wrap || fr[k])) begin
          for (int c = 0; c < 3; c++) dr[k][c] = sh[k][c];
          sf[k] = 1'b0;
          fr[k] = 1'b0;
        end else if (acc) begin
          for (int c = 0; c < 3; c++) sh[k][c] = in_d[c];
          sf[k] = 1'b1;
        end
        e[k] = en ? e[k] + 1 : 0;
        x.rdy[k] = !sf[k];
      end
      if (k == 0) x.rgb0 = rg;
      else        x.rgb1 = rg;
    end
  endtask

  task automatic cyc(input bit rst, input bit en, input bit vld,
                     input int r, input int g, input int b);
    exp_t x;
    @(negedge clk);
    reset    = rst;
    enable   = en;
    in_valid = vld;
    in_r     = r[7:0];
    in_g     = g[7:0];
    in_b     = b[7:0];
    model_step(rst, en, vld, r, g, b, x);
    q.push_back(x);
  endtask

  function automatic int rand_duty();
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return 255;
      2:       return 1;
      3:       return 254;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    total++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  // Monitor: compare one queued expectation per clock
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("in_ready0",     {2'b0, rdy0},   {2'b0, x.rdy[0]});
        check("period_start0", {2'b0, ps0},    {2'b0, x.ps[0]});
        check("rgb0",          {r0, g0, b0},   x.rgb0);
        check("in_ready1",     {2'b0, rdy1},   {2'b0, x.rdy[1]});
        check("period_start1", {2'b0, ps1},    {2'b0, x.ps[1]});
        check("rgb1",          {r1, g1, b1},   x.rgb1);
      end
    end
  end

  initial begin
    int  dis;
    bit  rs, en, vld;
    reset    = 1'b1;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_r     = '0;
    in_g     = '0;
    in_b     = '0;
    dis      = 0;

    // Reset, then run with nothing loaded
    repeat (3) cyc(1, 1, 0, 0, 0, 0);
    repeat (300) cyc(0, 1, 0, 0, 0, 0);

    // First load after reset goes live immediately
    cyc(0, 1, 1, 64, 128, 255);
    repeat (600) cyc(0, 1, 0, 0, 0, 0);

    // Randomized traffic with enable drops and rare resets
    for (int i = 0; i < 6000; i++) begin
      rs = ($urandom_range(0, 3999) == 0);
      if (dis == 0 && $urandom_range(0, 499) == 0) dis = int'($urandom_range(1, 60));
      en = (dis == 0);
      if (dis > 0) dis--;
      vld = ($urandom_range(0, 3) == 0);
      cyc(rs, en, vld, rand_duty(), rand_duty(), rand_duty());
    end

    // in_valid held high with a fresh triple every cycle
    repeat (2200) cyc(0, 1, 1, rand_duty(), rand_duty(), rand_duty());

    // Reset mid-operation, then a small red duty over a full slow period
    repeat (7) cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 3, 0, 0);
    repeat (1100) cyc(0, 1, 0, 0, 0, 0);

    // Drain the scoreboard within a bounded number of clocks
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #5;
    if (q.size() != 0) begin
      total++;
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
